conv_pool_layer: RTL and testbench

CONV_POOL_LAYER -- requirements
Module: conv_pool_layer

---
 rtl/conv_pool_layer.sv | 141 ++++++++++++++
 tb/tb_conv_pool_layer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_layer.sv
// conv_pool_layer: streaming KxK valid-mode convolution with shift/saturate/ReLU feeding a POOLxPOOL max-pool
module conv_pool_layer #(
  parameter int IMG_W = 8, IMG_H = 8, K = 3, POOL = 2, PW = 9, WW = 8, OW = 9, SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [PW-1:0]     pxl_in,
  input  logic                     pxl_valid,
  input  logic                     relu_en,
  input  logic                     w_we,
  input  logic [$clog2(K*K+1)-1:0] w_addr,
  input  logic signed [WW-1:0]     w_data,
  output logic                     w_err,
  output logic signed [OW-1:0]     pool_out,
  output logic                     valid,
  output logic                     frame_done
);
  localparam int NW = K*K;
  localparam int AB = $clog2(NW+1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PGW = (IMG_W-K+1)/POOL;
  localparam int PGH = (IMG_H-K+1)/POOL;
  localparam int BW = PGW > 1 ? $clog2(PGW) : 1;
  localparam int AW = PW+WW+$clog2(NW)+1;
  localparam logic [CW-1:0] CMAX = CW'(IMG_W-1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H-1);
  localparam logic [AB-1:0] BADDR = AB'(NW);
  localparam logic signed [AW-1:0] OMAX = AW'((1 << (OW-1)) - 1);
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [PW-1:0] lb_q [K-1][IMG_W];
  logic signed [PW-1:0] win_q [K][K];
  logic signed [PW-1:0] win_d [K][K];
  logic signed [WW-1:0] w_q [NW+1];
  logic s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d, s1_fd_q, s1_fd_d;
  logic [BW-1:0] s1_bx_q, s1_bx_d, s2_bx_q;
  logic s2_v_q, s2_first_q, s2_last_q, s2_fd_q;
  logic signed [OW-1:0] conv_q, conv_d, sat, nv, pool_q;
  logic signed [OW-1:0] mx_q [PGW];
  logic signed [AW-1:0] acc, sh;
  logic valid_q, fd_q, werr_q, idle, wr_ok;
  int cc, cr;

  assign col_d = pxl_valid ? (col_q == CMAX ? '0 : col_q + 1'b1) : col_q;
  assign row_d = (pxl_valid && col_q == CMAX) ? (row_q == RMAX ? '0 : row_q + 1'b1) : row_q;
  assign idle = row_q == '0 && col_q == '0 && !s1_v_q && !s2_v_q;
  assign wr_ok = w_we && idle && w_addr <= BADDR;

  // Window shifts left; the new right column is the line-buffer column topped off by the live pixel
  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K-1; j++)
        win_d[i][j] = win_q[i][j+1];
    for (int i = 0; i < K-1; i++)
      win_d[i][K-1] = lb_q[K-2-i][col_q];
    win_d[K-1][K-1] = pxl_in;
  end

  always_comb begin
    cc = int'(col_q) - (K-1);
    cr = int'(row_q) - (K-1);
    s1_v_d = pxl_valid && cc >= 0 && cr >= 0 && cc < PGW*POOL && cr < PGH*POOL;
    s1_first_d = cc % POOL == 0 && cr % POOL == 0;
    s1_last_d = cc % POOL == POOL-1 && cr % POOL == POOL-1;
    s1_fd_d = s1_last_d && cc / POOL == PGW-1 && cr / POOL == PGH-1;
    s1_bx_d = BW'(cc / POOL);
  end

  always_comb begin
    acc = AW'(w_q[NW]);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc = acc + AW'(win_q[i][j]) * AW'(w_q[i*K+j]);
    sh = acc >>> SHIFT;
    sat = sh > OMAX ? OMAX[OW-1:0] : sh < OMIN ? OMIN[OW-1:0] : sh[OW-1:0];
    conv_d = relu_en && sat[OW-1] ? '0 : sat;
  end

  assign nv = s2_first_q || conv_q > mx_q[s2_bx_q] ? conv_q : mx_q[s2_bx_q];

  always_ff @(posedge clk)
    if (pxl_valid) begin
      lb_q[0][col_q] <= pxl_in;
      for (int j = 1; j < K-1; j++)
        lb_q[j][col_q] <= lb_q[j-1][col_q];
    end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      w_q <= '{default: '0};
      mx_q <= '{default: '0};
      s1_v_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_fd_q <= 1'b0;
      s1_bx_q <= '0;
      s2_v_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_fd_q <= 1'b0;
      s2_bx_q <= '0;
      conv_q <= '0;
      pool_q <= '0;
      valid_q <= 1'b0;
      fd_q <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (pxl_valid) win_q <= win_d;
      if (wr_ok) w_q[w_addr] <= w_data;
      s1_v_q <= s1_v_d;
      s1_first_q <= s1_first_d;
      s1_last_q <= s1_last_d;
      s1_fd_q <= s1_fd_d;
      s1_bx_q <= s1_bx_d;
      s2_v_q <= s1_v_q;
      s2_first_q <= s1_first_q;
      s2_last_q <= s1_last_q;
      s2_fd_q <= s1_fd_q;
      s2_bx_q <= s1_bx_q;
      conv_q <= conv_d;
      if (s2_v_q) mx_q[s2_bx_q] <= nv;
      if (s2_v_q && s2_last_q) pool_q <= nv;
      valid_q <= s2_v_q && s2_last_q;
      fd_q <= s2_v_q && s2_last_q && s2_fd_q;
      werr_q <= w_we && !wr_ok;
    end
  end

  assign w_err = werr_q;
  assign pool_out = pool_q;
  assign valid = valid_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_conv_pool_layer.sv
// tb_conv_pool_layer: table-driven and randomized checks of conv_pool_layer against a frame-level reference model
module tb_conv_pool_layer;
  logic clk = 0, reset = 0, pxl_valid = 0, relu_en = 0, w_we = 0;
  logic signed [8:0] pxl_in = 0;
  logic [3:0] w_addr = 0;
  logic signed [7:0] w_data = 0;
  logic we0, we1, v0, v1, fd0, fd1;
  logic signed [8:0] po0, po1;

  conv_pool_layer #(.SHIFT(0)) dut0 (.clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_valid(pxl_valid),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(we0),
    .pool_out(po0), .valid(v0), .frame_done(fd0));
  conv_pool_layer #(.SHIFT(2)) dut1 (.clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_valid(pxl_valid),
    .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(we1),
    .pool_out(po1), .valid(v1), .frame_done(fd1));

  always #5 clk = ~clk;

  typedef struct { int cyc; int v0; int v1; bit fd; } exp_t;
  typedef struct packed {
    logic signed [7:0] wc;
    logic allone;
    logic ramp;
    logic signed [8:0] pix;
    logic relu;
    logic [8:0][8:0] e0;
    logic [8:0][8:0] e1;
  } vec_t;

  exp_t q[$];
  vec_t tab[4];
  vec_t v;
  int img[8][8];
  int wt[10];
  int ev0[9], ev1[9];
  int cyc = 0, tests = 0, fails = 0, last0 = 0, last1 = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  function automatic int post(int s, int sh);
    int x = s >>> sh;
    if (x > 255) x = 255;
    if (x < -256) x = -256;
    if (relu_en && x < 0) x = 0;
    return x;
  endfunction

  // Whole-frame reference: convolve every conv position, then take the max of each 2x2 block
  function automatic void model();
    for (int by = 0; by < 3; by++)
      for (int bx = 0; bx < 3; bx++) begin
        int m0 = -1000000;
        int m1 = -1000000;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            int s = wt[9];
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                s += wt[i*3+j] * img[2*by+dy+i][2*bx+dx+j];
            if (post(s, 0) > m0) m0 = post(s, 0);
            if (post(s, 2) > m1) m1 = post(s, 2);
          end
        ev0[by*3+bx] = m0;
        ev1[by*3+bx] = m1;
      end
  endfunction

  task automatic load_w();
    for (int a = 0; a < 10; a++) begin
      w_we = 1;
      w_addr = 4'(a);
      w_data = 8'(wt[a]);
      tick();
      chk("w_err_on_load", int'({we0, we1}), 0);
    end
    w_we = 0;
  endtask

  task automatic run_frame(input int gap, input int from, input int to);
    for (int p = from; p <= to; p++) begin
      int r, c, k;
      while (int'($urandom_range(99)) < gap) begin
        pxl_valid = 0;
        pxl_in = 9'($urandom);
        tick();
      end
      r = p / 8;
      c = p % 8;
      pxl_in = 9'(img[r][c]);
      pxl_valid = 1;
      if (r >= 3 && c >= 3 && r % 2 == 1 && c % 2 == 1) begin
        k = ((r-3)/2)*3 + (c-3)/2;
        q.push_back(exp_t'{cyc+3, ev0[k], ev1[k], k == 8});
      end
      tick();
    end
    pxl_valid = 0;
  endtask

  always @(negedge clk) if (mon_en) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("valid0", int'(v0), 1);
      chk("valid1", int'(v1), 1);
      chk("pool_out0", int'(po0), q[0].v0);
      chk("pool_out1", int'(po1), q[0].v1);
      chk("frame_done", int'({fd0, fd1}), q[0].fd ? 3 : 0);
      last0 = q[0].v0;
      last1 = q[0].v1;
      void'(q.pop_front());
    end else
      chk("idle_outputs_hold", int'({v0, v1, fd0, fd1, po0 == 9'(last0), po1 == 9'(last1)}), 3);
    if (!reset) begin
      last0 = 0;
      last1 = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tab[0] = '{wc: 8'sd1, allone: 1'b0, ramp: 1'b1, pix: 9'sd0, relu: 1'b0,
               e0: {9'd54, 9'd52, 9'd50, 9'd38, 9'd36, 9'd34, 9'd22, 9'd20, 9'd18},
               e1: {9'd13, 9'd13, 9'd12, 9'd9, 9'd9, 9'd8, 9'd5, 9'd5, 9'd4}};
    tab[1] = '{wc: 8'sd0, allone: 1'b1, ramp: 1'b0, pix: 9'sd100, relu: 1'b0,
               e0: {9{9'd255}}, e1: {9{9'd225}}};
    tab[2] = '{wc: -8'sd1, allone: 1'b0, ramp: 1'b0, pix: 9'sd10, relu: 1'b0,
               e0: {9{9'h1F6}}, e1: {9{9'h1FD}}};
    tab[3] = '{wc: -8'sd1, allone: 1'b0, ramp: 1'b0, pix: 9'sd10, relu: 1'b1,
               e0: '0, e1: '0};
    repeat (3) tick();
    chk("reset_valid", int'({v0, v1}), 0);
    chk("reset_pool_out", int'({po0, po1}), 0);
    chk("reset_w_err", int'({we0, we1}), 0);
    chk("reset_frame_done", int'({fd0, fd1}), 0);
    reset = 1;
    mon_en = 1;
    tick();
    for (int t = 0; t < 5; t++) begin
      v = tab[t == 4 ? 0 : t];
      relu_en = v.relu;
      for (int a = 0; a < 10; a++) wt[a] = 0;
      if (v.allone) for (int a = 0; a < 9; a++) wt[a] = 1;
      else wt[4] = int'(v.wc);
      load_w();
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          img[r][c] = v.ramp ? r*8 + c : int'(v.pix);
      for (int k = 0; k < 9; k++) begin
        ev0[k] = int'($signed(v.e0[k]));
        ev1[k] = int'($signed(v.e1[k]));
      end
      run_frame(t == 4 ? 40 : 0, 0, 63);
      drain();
    end
    w_we = 1;
    w_addr = 4'd10;
    w_data = 8'sd55;
    tick();
    chk("w_err_bad_addr", int'({we0, we1}), 3);
    w_we = 0;
    tick();
    chk("w_err_pulse_end", int'({we0, we1}), 0);
    run_frame(10, 0, 63);
    drain();
    for (int f = 0; f < 6; f++) begin
      relu_en = 1'($urandom_range(1));
      for (int a = 0; a < 10; a++) wt[a] = int'($urandom_range(a == 9 ? 255 : 15)) - (a == 9 ? 128 : 8);
      load_w();
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          img[r][c] = int'($urandom_range(511)) - 256;
      model();
      run_frame(int'($urandom_range(50)), 0, 63);
      drain();
    end
    relu_en = 0;
    for (int a = 0; a < 10; a++) wt[a] = int'($urandom_range(15)) - 8;
    load_w();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = int'($urandom_range(511)) - 256;
    model();
    run_frame(20, 0, 20);
    w_we = 1;
    w_addr = 4'd4;
    w_data = 8'sd77;
    tick();
    chk("w_err_busy", int'({we0, we1}), 3);
    w_we = 0;
    tick();
    chk("w_err_one_cycle", int'({we0, we1}), 0);
    run_frame(20, 21, 63);
    drain();
    run_frame(0, 0, 29);
    reset = 0;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    tick();
    chk("reset_mid_flags", int'({v0, v1, fd0, fd1, we0, we1}), 0);
    chk("reset_mid_pool_out", int'({po0, po1}), 0);
    reset = 1;
    for (int a = 0; a < 10; a++) wt[a] = 0;
    model();
    run_frame(30, 0, 63);
    drain();
    chk("all_outputs_seen", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
